// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with byte-lane data RAM, sync load extract and MEM/WB register.
// Optional MEM_DEBUG_PORT_EN adds a second registered read port (i_dbg_addr/o_dbg_data).
module mem_access_stage #(
    parameter int ADDR_W    = 10,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MEM_DEBUG_PORT_EN
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [31:0]       o_dbg_data,
`endif
    input  logic              i_stall,
    input  logic [31:0]       i_ALU_res,
    input  logic [31:0]       i_rt_reg,
    input  logic [31:0]       i_pc_to_reg,
    input  logic [4:0]        i_addr_reg_dst,
    input  logic              is_RegWrite,
    input  logic              is_MemtoReg,
    input  logic              is_MemWrite,
    input  logic              is_MemRead,
    input  logic              is_select_addr_reg,
    input  logic [2:0]        is_load_store_type,
    output logic [31:0]       o_read_data,
    output logic [31:0]       o_ALU_res,
    output logic [31:0]       o_pc_to_reg,
    output logic [4:0]        o_addr_reg_dst,
    output logic              os_RegWrite,
    output logic              os_MemtoReg,
    output logic              os_select_addr_reg,
    output logic              os_misaligned
);
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic [1:0]        off, off_q;
    logic [2:0]        t_q;
    logic              is_b, is_h, mis, we, ld_q;
    logic [3:0]        be;
    logic [31:0]       wdata, rd_q;
    logic [7:0]        b;
    logic [15:0]       h;
    logic              unused;

    assign unused = ^i_ALU_res[31:ADDR_W+2];
    assign idx    = i_ALU_res[ADDR_W+1:2];
    assign off    = i_ALU_res[1:0];
    // Type low bits: 00 byte, 01 half, anything else (incl. reserved codes) is a word.
    assign is_b   = is_load_store_type[1:0] == 2'b00;
    assign is_h   = is_load_store_type[1:0] == 2'b01;
    assign mis    = (is_MemRead | is_MemWrite) & (is_h ? off[0] : (!is_b && off != 2'b00));
    assign we     = is_MemWrite & ~i_stall & ~mis & ~rst;
    assign be     = is_b ? 4'b0001 << off : is_h ? 4'b0011 << off : 4'b1111;
    assign wdata  = is_b ? {4{i_rt_reg[7:0]}} : is_h ? {2{i_rt_reg[15:0]}} : i_rt_reg;

    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        if (!i_stall) rd_q <= mem[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            off_q              <= '0;
            t_q                <= '0;
            ld_q               <= 1'b0;
            o_ALU_res          <= '0;
            o_pc_to_reg        <= '0;
            o_addr_reg_dst     <= '0;
            os_RegWrite        <= 1'b0;
            os_MemtoReg        <= 1'b0;
            os_select_addr_reg <= 1'b0;
            os_misaligned      <= 1'b0;
        end else if (!i_stall) begin
            off_q              <= off;
            t_q                <= is_load_store_type;
            ld_q               <= is_MemRead & ~is_MemWrite & ~mis;
            o_ALU_res          <= i_ALU_res;
            o_pc_to_reg        <= i_pc_to_reg;
            o_addr_reg_dst     <= i_addr_reg_dst;
            os_RegWrite        <= is_RegWrite & ~mis;
            os_MemtoReg        <= is_MemtoReg;
            os_select_addr_reg <= is_select_addr_reg;
            os_misaligned      <= mis;
        end
    end

    // Extraction runs on the registered offset/type so it lines up with the sync RAM read.
    assign b = rd_q[{off_q, 3'b000} +: 8];
    assign h = rd_q[{off_q[1], 4'b0000} +: 16];

    always_comb
        o_read_data = !ld_q ? 32'h0 :
                      t_q[1:0] == 2'b00 ? {{24{b[7] & ~t_q[2]}}, b} :
                      t_q[1:0] == 2'b01 ? {{16{h[15] & ~t_q[2]}}, h} : rd_q;

`ifdef MEM_DEBUG_PORT_EN
    always_ff @(posedge clk)
        o_dbg_data <= rst ? 32'h0 : mem[i_dbg_addr];
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of mem_access_stage with immediate assertions.
module tb_mem_access_stage;
    logic        clk = 0, rst = 0, i_stall = 0;
    logic [31:0] i_ALU_res = 0, i_rt_reg = 0, i_pc_to_reg = 0;
    logic [4:0]  i_addr_reg_dst = 0;
    logic        is_RegWrite = 0, is_MemtoReg = 0, is_MemWrite = 0, is_MemRead = 0, is_select_addr_reg = 0;
    logic [2:0]  is_load_store_type = 0;
    logic [31:0] o_read_data, o_ALU_res, o_pc_to_reg;
    logic [4:0]  o_addr_reg_dst;
    logic        os_RegWrite, os_MemtoReg, os_select_addr_reg, os_misaligned;
    int          passed = 0, total = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_ALU_res(i_ALU_res), .i_rt_reg(i_rt_reg),
        .i_pc_to_reg(i_pc_to_reg), .i_addr_reg_dst(i_addr_reg_dst), .is_RegWrite(is_RegWrite),
        .is_MemtoReg(is_MemtoReg), .is_MemWrite(is_MemWrite), .is_MemRead(is_MemRead),
        .is_select_addr_reg(is_select_addr_reg), .is_load_store_type(is_load_store_type),
        .o_read_data(o_read_data), .o_ALU_res(o_ALU_res), .o_pc_to_reg(o_pc_to_reg),
        .o_addr_reg_dst(o_addr_reg_dst), .os_RegWrite(os_RegWrite), .os_MemtoReg(os_MemtoReg),
        .os_select_addr_reg(os_select_addr_reg), .os_misaligned(os_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                      input logic w, input logic r, input logic rw, input logic st);
        i_ALU_res = a; i_rt_reg = d; is_load_store_type = t;
        is_MemWrite = w; is_MemRead = r; is_RegWrite = rw; is_MemtoReg = r;
        i_stall = st; is_select_addr_reg = 0; i_pc_to_reg = a + 4; i_addr_reg_dst = 5'd5;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset with every input nonzero, stall asserted too
        rst = 1; i_stall = 1; i_ALU_res = 32'h13; i_rt_reg = 32'hFFFF; i_pc_to_reg = 32'h44;
        i_addr_reg_dst = 5'd7; is_RegWrite = 1; is_MemtoReg = 1; is_MemWrite = 1; is_MemRead = 1;
        is_select_addr_reg = 1; is_load_store_type = 3'b001;
        @(posedge clk); #1;
        chk("rst_read", o_read_data, 0);
        chk("rst_alu", o_ALU_res, 0);
        chk("rst_pc", o_pc_to_reg, 0);
        chk("rst_dst", {27'h0, o_addr_reg_dst}, 0);
        chk("rst_flags", {28'h0, os_RegWrite, os_MemtoReg, os_select_addr_reg, os_misaligned}, 0);
        rst = 0;
        // Word store/load and sub-word extraction
        op(32'h10, 32'hDEADBEEF, 3'b011, 1, 0, 0, 0);
        chk("sw_read0", o_read_data, 0);
        chk("sw_alu", o_ALU_res, 32'h10);
        chk("sw_mis", {31'h0, os_misaligned}, 0);
        op(32'h10, 0, 3'b011, 0, 1, 1, 0);
        chk("lw", o_read_data, 32'hDEADBEEF);
        chk("lw_rw", {31'h0, os_RegWrite}, 1);
        chk("lw_dst", {27'h0, o_addr_reg_dst}, 5);
        chk("lw_pc", o_pc_to_reg, 32'h14);
        op(32'h12, 0, 3'b001, 0, 1, 1, 0); chk("lh", o_read_data, 32'hFFFFDEAD);
        op(32'h10, 0, 3'b101, 0, 1, 1, 0); chk("lhu", o_read_data, 32'h0000BEEF);
        op(32'h13, 0, 3'b000, 0, 1, 1, 0); chk("lb", o_read_data, 32'hFFFFFFDE);
        op(32'h11, 0, 3'b100, 0, 1, 1, 0); chk("lbu", o_read_data, 32'h000000BE);
        // Byte store into one lane
        op(32'h20, 32'h11223344, 3'b011, 1, 0, 0, 0);
        op(32'h21, 32'hAAAAAA80, 3'b000, 1, 0, 0, 0);
        op(32'h21, 0, 3'b000, 0, 1, 1, 0); chk("sb_lb", o_read_data, 32'hFFFFFF80);
        op(32'h21, 0, 3'b100, 0, 1, 1, 0); chk("sb_lbu", o_read_data, 32'h00000080);
        op(32'h20, 0, 3'b011, 0, 1, 1, 0); chk("sb_lw", o_read_data, 32'h11228044);
        // Misaligned half store, then stall holds the pulse
        op(32'h13, 32'h5555, 3'b001, 1, 0, 1, 0);
        chk("mis_sh", {31'h0, os_misaligned}, 1);
        chk("mis_rw", {31'h0, os_RegWrite}, 0);
        op(32'h40, 32'h1, 3'b011, 1, 0, 1, 1);
        chk("mis_stall", {31'h0, os_misaligned}, 1);
        op(32'h10, 0, 3'b011, 0, 1, 1, 0);
        chk("mis_nowrite", o_read_data, 32'hDEADBEEF);
        chk("mis_pulse", {31'h0, os_misaligned}, 0);
        op(32'h12, 0, 3'b011, 0, 1, 1, 0);
        chk("mis_lw_data", o_read_data, 0);
        chk("mis_lw_flag", {30'h0, os_misaligned, os_RegWrite}, 32'h2);
        // Aligned upper half store
        op(32'h12, 32'h1234CAFE, 3'b001, 1, 0, 0, 0);
        op(32'h40, 32'h5678, 3'b011, 1, 0, 0, 0);
        op(32'h10, 0, 3'b011, 0, 1, 1, 0); chk("sh_lw", o_read_data, 32'hCAFEBEEF);
        // Stall freezes outputs and blocks the write
        op(32'h40, 32'h1234, 3'b011, 1, 0, 0, 1);
        chk("stall_alu", o_ALU_res, 32'h10);
        chk("stall_read", o_read_data, 32'hCAFEBEEF);
        chk("stall_rw", {31'h0, os_RegWrite}, 1);
        op(32'h40, 0, 3'b011, 0, 1, 1, 0); chk("stall_nowrite", o_read_data, 32'h5678);
        // Read+write together: write done, no load data
        op(32'h30, 32'h77, 3'b011, 1, 1, 0, 0); chk("rw_both", o_read_data, 0);
        op(32'h30, 0, 3'b011, 0, 1, 1, 0); chk("rw_after", o_read_data, 32'h77);
        // Address wrap and reserved type codes
        op(32'h1010, 0, 3'b011, 0, 1, 1, 0); chk("wrap", o_read_data, 32'hCAFEBEEF);
        op(32'h50, 32'h99, 3'b110, 1, 0, 0, 0);
        op(32'h50, 0, 3'b111, 0, 1, 1, 0); chk("reserved", o_read_data, 32'h99);
        op(32'h52, 0, 3'b010, 0, 1, 1, 0); chk("reserved_mis", {31'h0, os_misaligned}, 1);
        // Link-style write-back
        i_ALU_res = 32'h13; is_load_store_type = 3'b001; is_MemRead = 0; is_MemWrite = 0;
        is_MemtoReg = 0; is_RegWrite = 1; is_select_addr_reg = 1; i_pc_to_reg = 32'h400;
        i_addr_reg_dst = 5'd31; i_stall = 0;
        @(posedge clk); #1;
        chk("jal_pc", o_pc_to_reg, 32'h400);
        chk("jal_flags", {28'h0, os_RegWrite, os_MemtoReg, os_select_addr_reg, os_misaligned}, 32'hA);
        chk("jal_dst", {27'h0, o_addr_reg_dst}, 31);
        chk("jal_read", o_read_data, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
